// File: rtl/freq_div_scheduler.sv
// Frequency result scheduler: one shared bit-serial restoring divider computes
// freq_i = pulse_cnt_i * REF_HZ / std_cnt for channels 0..3 in order after each
// gate-close start pulse.
//
// state | meaning
// IDLE  | waiting for start; snapshot taken on the start cycle
// LOAD  | form 64-bit numerator for channel ch, clear divider
// DIV   | 64 restoring-division steps, MSB first
// STORE | commit quotient (saturated) to freq[ch], advance channel
// DONE  | one-cycle valid; sat/div_zero already presented
module freq_div_scheduler #(
    parameter logic [31:0] REF_HZ = 32'd20_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] std_cnt,
    input  logic [31:0] pulse_cnt_0,
    input  logic [31:0] pulse_cnt_1,
    input  logic [31:0] pulse_cnt_2,
    input  logic [31:0] pulse_cnt_3,
    output logic [31:0] freq_0,
    output logic [31:0] freq_1,
    output logic [31:0] freq_2,
    output logic [31:0] freq_3,
    output logic        busy,
    output logic        valid,
    output logic [3:0]  sat,
    output logic        div_zero,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       snap_std_q, snap_std_d;
    logic [3:0][31:0]  snap_pulse_q, snap_pulse_d;
    logic [1:0]        ch_q, ch_d;
    logic [63:0]       num_q, num_d;
    // Remainder is always < snap_std, so 32 bits hold it between steps; the
    // shifted partial remainder needs the extra bit only for the compare.
    logic [31:0]       rem_q, rem_d;
    logic [63:0]       quo_q, quo_d;
    logic [5:0]        iter_q, iter_d;
    logic [3:0][31:0]  freq_q, freq_d;
    logic [3:0]        sat_sh_q, sat_sh_d;
    logic [3:0]        sat_q, sat_d;
    logic              div_zero_q, div_zero_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [32:0]       rem_sh;

    // State and datapath registers; reset clears everything and aborts a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_std_q   <= '0;
            snap_pulse_q <= '0;
            ch_q         <= '0;
            num_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            freq_q       <= '0;
            sat_sh_q     <= '0;
            sat_q        <= '0;
            div_zero_q   <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_std_q   <= snap_std_d;
            snap_pulse_q <= snap_pulse_d;
            ch_q         <= ch_d;
            num_q        <= num_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            iter_q       <= iter_d;
            freq_q       <= freq_d;
            sat_sh_q     <= sat_sh_d;
            sat_q        <= sat_d;
            div_zero_q   <= div_zero_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state and datapath logic. Status outputs are loaded on the
    // transition into DONE so they are visible in the same cycle as valid.
    always_comb begin
        state_d      = state_q;
        snap_std_d   = snap_std_q;
        snap_pulse_d = snap_pulse_q;
        ch_d         = ch_q;
        num_d        = num_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        iter_d       = iter_q;
        freq_d       = freq_q;
        sat_sh_d     = sat_sh_q;
        sat_d        = sat_q;
        div_zero_d   = div_zero_q;
        valid_d      = 1'b0;
        overrun_d    = start && (state_q != IDLE);
        rem_sh       = {rem_q, num_q[iter_q]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_std_d   = std_cnt;
                    snap_pulse_d = {pulse_cnt_3, pulse_cnt_2, pulse_cnt_1, pulse_cnt_0};
                    ch_d         = 2'd0;
                    sat_sh_d     = '0;
                    if (std_cnt == 32'd0) begin
                        state_d    = DONE;
                        freq_d     = '0;
                        sat_d      = '0;
                        div_zero_d = 1'b1;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                num_d   = 64'(snap_pulse_q[ch_q]) * 64'(REF_HZ);
                rem_d   = '0;
                quo_d   = '0;
                iter_d  = 6'd63;
                state_d = DIV;
            end
            DIV: begin
                if (rem_sh >= {1'b0, snap_std_q}) begin
                    // True difference is below snap_std, so mod-2^32 is exact.
                    rem_d         = rem_sh[31:0] - snap_std_q;
                    quo_d[iter_q] = 1'b1;
                end else begin
                    rem_d         = rem_sh[31:0];
                    quo_d[iter_q] = 1'b0;
                end
                if (iter_q == 6'd0) begin
                    state_d = STORE;
                end else begin
                    iter_d = iter_q - 6'd1;
                end
            end
            STORE: begin
                if (|quo_q[63:32]) begin
                    freq_d[ch_q]   = 32'hFFFF_FFFF;
                    sat_sh_d[ch_q] = 1'b1;
                end else begin
                    freq_d[ch_q]   = quo_q[31:0];
                    sat_sh_d[ch_q] = 1'b0;
                end
                if (ch_q == 2'd3) begin
                    state_d    = DONE;
                    valid_d    = 1'b1;
                    sat_d      = sat_sh_d;
                    div_zero_d = 1'b0;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign freq_0   = freq_q[0];
    assign freq_1   = freq_q[1];
    assign freq_2   = freq_q[2];
    assign freq_3   = freq_q[3];
    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign sat      = sat_q;
    assign div_zero = div_zero_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_freq_div_scheduler.sv
// Bench for freq_div_scheduler: driver pushes model results into a scoreboard,
// a negedge monitor pops and compares whenever valid or overrun is presented.
module tb_freq_div_scheduler;

    localparam logic [31:0] REF_HZ = 32'd20_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] std_cnt, pulse_cnt_0, pulse_cnt_1, pulse_cnt_2, pulse_cnt_3;
    logic [31:0] freq_0, freq_1, freq_2, freq_3;
    logic        busy, valid, div_zero, overrun;
    logic [3:0]  sat;

    freq_div_scheduler #(.REF_HZ(REF_HZ)) dut (
        .clk(clk), .rst(rst), .start(start), .std_cnt(std_cnt),
        .pulse_cnt_0(pulse_cnt_0), .pulse_cnt_1(pulse_cnt_1),
        .pulse_cnt_2(pulse_cnt_2), .pulse_cnt_3(pulse_cnt_3),
        .freq_0(freq_0), .freq_1(freq_1), .freq_2(freq_2), .freq_3(freq_3),
        .busy(busy), .valid(valid), .sat(sat), .div_zero(div_zero),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0][31:0] f;
        logic [3:0]       sat;
        logic             dz;
        int               vcyc;
        int               blen;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   busy_run = 0;
    logic [3:0][31:0] cur_f = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact 64-bit arithmetic, floor division, clamp to 32 bits.
    function automatic exp_t model(input logic [31:0] sd, input logic [3:0][31:0] pcs);
        exp_t e;
        longint unsigned n, q;
        e.f = '0; e.sat = '0; e.dz = 1'b0; e.vcyc = 0; e.blen = 0;
        if (sd == 0) begin
            e.dz = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n = longint'(pcs[i]) * longint'(REF_HZ);
                q = n / longint'(sd);
                if (q > 64'h0000_0000_FFFF_FFFF) begin
                    e.f[i] = 32'hFFFF_FFFF;
                    e.sat[i] = 1'b1;
                end else begin
                    e.f[i] = q[31:0];
                end
            end
        end
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        int   oc;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++; else busy_run = 0;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("freq_0", 64'(freq_0), 64'(e.f[0]));
                    check("freq_1", 64'(freq_1), 64'(e.f[1]));
                    check("freq_2", 64'(freq_2), 64'(e.f[2]));
                    check("freq_3", 64'(freq_3), 64'(e.f[3]));
                    check("sat", 64'(sat), 64'(e.sat));
                    check("div_zero", 64'(div_zero), 64'(e.dz));
                    check("valid_cycle", 64'(cyc), 64'(e.vcyc));
                    check("busy_len", 64'(busy_run), 64'(e.blen));
                end
            end
            if (overrun) begin
                if (ovr_q.size() == 0) begin
                    check("spurious_overrun", 64'(overrun), 64'd0);
                end else begin
                    oc = ovr_q.pop_front();
                    check("overrun_cycle", 64'(cyc), 64'(oc));
                end
            end
        end
    end

    task automatic scramble();
        std_cnt     = $urandom;
        pulse_cnt_0 = $urandom;
        pulse_cnt_1 = $urandom;
        pulse_cnt_2 = $urandom;
        pulse_cnt_3 = $urandom;
    endtask

    // Drives one start pulse; returns at the negedge in cycle 1 of the run.
    task automatic issue(input logic [31:0] sd, input logic [3:0][31:0] pcs);
        exp_t e;
        @(negedge clk);
        std_cnt = sd;
        pulse_cnt_0 = pcs[0]; pulse_cnt_1 = pcs[1];
        pulse_cnt_2 = pcs[2]; pulse_cnt_3 = pcs[3];
        start = 1'b1;
        e = model(sd, pcs);
        e.vcyc = cyc + ((sd == 0) ? 1 : 265);
        e.blen = (sd == 0) ? 1 : 265;
        exp_q.push_back(e);
        cur_f = e.f;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero_outputs();
        check("rst_freq_0", 64'(freq_0), 64'd0);
        check("rst_freq_1", 64'(freq_1), 64'd0);
        check("rst_freq_2", 64'(freq_2), 64'd0);
        check("rst_freq_3", 64'(freq_3), 64'd0);
        check("rst_flags", 64'({busy, valid, sat, div_zero, overrun}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] old_f;
        logic [31:0]      sd;
        logic [3:0][31:0] pcs;
        rst = 1'b1; start = 1'b0;
        std_cnt = '0; pulse_cnt_0 = '0; pulse_cnt_1 = '0; pulse_cnt_2 = '0; pulse_cnt_3 = '0;
        #1;
        check_zero_outputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Nominal run plus partial-update boundary around channel 0 store.
        old_f = cur_f;
        issue(32'd200000, {32'd5000000, 32'd0, 32'd1, 32'd10000});
        repeat (65) @(negedge clk);
        check("ch0_before_store", 64'(freq_0), 64'(old_f[0]));
        @(negedge clk);
        check("ch0_after_store", 64'(freq_0), 64'd1000000);
        check("ch1_still_old", 64'(freq_1), 64'(old_f[1]));
        wait_idle();

        issue(32'd199999, {32'd7, 32'd7, 32'd7, 32'd3});
        wait_idle();
        issue(32'd1, {32'd1, 32'd0, 32'd214, 32'hFFFF_FFFF});
        wait_idle();
        issue(32'd0, {32'd9, 32'd8, 32'd7, 32'd6});
        wait_idle();
        issue(32'd200000, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_idle();

        // start at cycle 100 with inputs changed at cycle 50.
        issue(32'd123457, {32'd99, 32'd777, 32'd123456, 32'd42});
        repeat (49) @(negedge clk);
        scramble();
        repeat (50) @(negedge clk);
        start = 1'b1;
        ovr_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start during DONE (cycle 265): ignored, overrun only.
        issue(32'd300000, {32'd11, 32'd22, 32'd33, 32'd44});
        repeat (264) @(negedge clk);
        start = 1'b1;
        ovr_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);

        // Reset at cycle 120 aborts; a fresh run then completes normally.
        issue(32'd50000, {32'd5, 32'd6, 32'd7, 32'd8});
        repeat (119) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs();
        exp_q.delete();
        cur_f = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(32'd250000, {32'd1000, 32'd2000, 32'd3000, 32'd4000});
        wait_idle();

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 4))
                0:       sd = 32'd0;
                1:       sd = $urandom_range(1, 50);
                2:       sd = $urandom_range(100000, 300000);
                default: sd = $urandom;
            endcase
            for (int i = 0; i < 4; i++)
                pcs[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 100000);
            issue(sd, pcs);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("overrun_drain", 64'(ovr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
